// File: rtl/pattern_checker_32bit.sv
// Drains a pipe-in FIFO and checks each word against a regenerated test pattern; PATTERN_CHECKER_CAPTURE_EN builds first-error capture.
// Read-to-counter latency 2 edges, one word/cycle; reads pause while fifo_empty is high, no reads once expected_words are issued.
module pattern_checker_32bit #(
  parameter int FIFO_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pattern,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] expected_words,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_dout,
  output logic [63:0] word_count,
  output logic [31:0] error_count,
  output logic        busy,
  output logic        done,
  output logic        error_flag,
  output logic [31:0] first_err_index,
  output logic [31:0] first_err_expected,
  output logic [31:0] first_err_received
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Only a one-cycle FIFO read latency is handled; any other setting never issues reads.
  localparam bit LAT_SUPPORTED = (FIFO_RD_LATENCY == 1);

  localparam logic [2:0] PAT_COUNTER = 3'd0;
  localparam logic [2:0] PAT_WALK    = 3'd1;
  localparam logic [2:0] PAT_LFSR    = 3'd2;
  localparam logic [2:0] PAT_ALT     = 3'd3;

  state_t      state, state_nxt;
  logic [31:0] issued;
  logic        rd_valid;
  logic [2:0]  pat_sel;
  logic [31:0] gen_word;
  logic [31:0] gen_next;
  logic [31:0] seed;
  logic        more_to_read;
  logic        last_read;
  logic        compare;
  logic        mismatch;

  assign more_to_read = (expected_words == 32'd0) || (issued < expected_words);
  assign last_read    = (expected_words != 32'd0) &&
                        ((fifo_rd_en && (issued + 32'd1 == expected_words)) || !more_to_read);
  // A word already in flight when start arrives belongs to the old run and is dropped.
  assign compare      = rd_valid && !start;
  assign mismatch     = compare && (fifo_dout != gen_word);

  always_comb begin
    seed = 32'd0;
    case (pattern[2:0])
      PAT_COUNTER: seed = 32'd0;
      PAT_WALK:    seed = 32'd1;
      PAT_LFSR:    seed = 32'd1;
      PAT_ALT:     seed = 32'hAAAA_AAAA;
      default:     seed = {3'b000, pattern[31:3]};
    endcase
  end

  always_comb begin
    gen_next = gen_word;
    case (pat_sel)
      PAT_COUNTER: gen_next = gen_word + 32'd1;
      PAT_WALK:    gen_next = {gen_word[30:0], gen_word[31]};
      PAT_LFSR:    gen_next = {gen_word[30:0],
                               gen_word[31] ^ gen_word[21] ^ gen_word[1] ^ gen_word[0]};
      PAT_ALT:     gen_next = ~gen_word;
      default:     gen_next = gen_word;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (stop || last_read) state_nxt = S_DRAIN;
        S_DRAIN: state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    fifo_rd_en = LAT_SUPPORTED && (state == S_RUN) && !fifo_empty && more_to_read;
    busy       = (state == S_RUN) || (state == S_DRAIN);
    done       = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued      <= 32'd0;
      rd_valid    <= 1'b0;
      pat_sel     <= 3'd0;
      gen_word    <= 32'd0;
      word_count  <= 64'd0;
      error_count <= 32'd0;
      error_flag  <= 1'b0;
    end else begin
      rd_valid <= fifo_rd_en;
      if (start) begin
        // A strobe issued in the start cycle is the first read of the new run.
        issued      <= {31'd0, fifo_rd_en};
        pat_sel     <= pattern[2:0];
        gen_word    <= seed;
        word_count  <= 64'd0;
        error_count <= 32'd0;
        error_flag  <= 1'b0;
      end else begin
        if (fifo_rd_en) issued <= issued + 32'd1;
        if (compare) begin
          word_count <= word_count + 64'd1;
          gen_word   <= gen_next;
          if (mismatch) begin
            if (error_count != 32'hFFFF_FFFF) error_count <= error_count + 32'd1;
            error_flag <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PATTERN_CHECKER_CAPTURE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_err_index    <= 32'd0;
      first_err_expected <= 32'd0;
      first_err_received <= 32'd0;
    end else if (start) begin
      first_err_index    <= 32'd0;
      first_err_expected <= 32'd0;
      first_err_received <= 32'd0;
    end else if (mismatch && !error_flag) begin
      first_err_index    <= word_count[31:0];
      first_err_expected <= gen_word;
      first_err_received <= fifo_dout;
    end
  end
`else
  assign first_err_index    = 32'd0;
  assign first_err_expected = 32'd0;
  assign first_err_received = 32'd0;
`endif

endmodule

// File: tb/tb_pattern_checker_32bit.sv
// Scoreboard bench: each run pushes its expected end-of-run result; the monitor checks it when done rises.
module tb_pattern_checker_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pattern;
  logic        start;
  logic        stop;
  logic [31:0] expected_words;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout;
  logic [63:0] word_count;
  logic [31:0] error_count;
  logic        busy;
  logic        done;
  logic        error_flag;
  logic [31:0] first_err_index;
  logic [31:0] first_err_expected;
  logic [31:0] first_err_received;

  pattern_checker_32bit #(.FIFO_RD_LATENCY(1)) dut (
    .clk                (clk),
    .reset              (reset),
    .pattern            (pattern),
    .start              (start),
    .stop               (stop),
    .expected_words     (expected_words),
    .fifo_empty         (fifo_empty),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_dout          (fifo_dout),
    .word_count         (word_count),
    .error_count        (error_count),
    .busy               (busy),
    .done               (done),
    .error_flag         (error_flag),
    .first_err_index    (first_err_index),
    .first_err_expected (first_err_expected),
    .first_err_received (first_err_received)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] wc;
    logic [31:0] ec;
    logic        ef;
    logic [31:0] ci;
    logic [31:0] ce;
    logic [31:0] cr;
    int          reads;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // FIFO model: one-cycle read latency, occupancy tracked as pushes minus pops.
  logic [31:0] fq[$];
  int          push_cnt = 0;
  int          pop_cnt  = 0;
  logic        empty_force = 1'b0;

  always @* fifo_empty = empty_force || ((push_cnt - pop_cnt) <= 0);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() > 0) fifo_dout <= fq.pop_front();
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [63:0] wc, input logic [31:0] ec,
                              input logic ef, input logic [31:0] ci, input logic [31:0] ce,
                              input logic [31:0] cr, input int reads);
    exp_t e;
    e.id = id; e.wc = wc; e.ec = ec; e.ef = ef; e.reads = reads;
`ifdef PATTERN_CHECKER_CAPTURE_EN
    e.ci = ci; e.ce = ce; e.cr = cr;
`else
    e.ci = 32'd0; e.ce = 32'd0; e.cr = 32'd0;
    if (ci != ce && cr == 32'hFFFF_FFFF) e.id = id;
`endif
    return e;
  endfunction

  // Monitor: counts strobes per run and checks the final result when done rises.
  int   cyc = 0;
  int   rd_cnt = 0;
  int   viol = 0;
  int   last_rd = 0;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (start) begin
      rd_cnt = 0;
      viol   = 0;
    end
    if (fifo_rd_en) begin
      rd_cnt++;
      last_rd = cyc;
      if (fifo_empty) viol++;
    end
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done");
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("t%0d_word_count", e.id), word_count, e.wc);
        chk($sformatf("t%0d_error_count", e.id), {32'd0, error_count}, {32'd0, e.ec});
        chk($sformatf("t%0d_error_flag", e.id), {63'd0, error_flag}, {63'd0, e.ef});
        chk($sformatf("t%0d_cap_index", e.id), {32'd0, first_err_index}, {32'd0, e.ci});
        chk($sformatf("t%0d_cap_expected", e.id), {32'd0, first_err_expected}, {32'd0, e.ce});
        chk($sformatf("t%0d_cap_received", e.id), {32'd0, first_err_received}, {32'd0, e.cr});
        chk($sformatf("t%0d_reads", e.id), 64'(rd_cnt), 64'(e.reads));
        chk($sformatf("t%0d_read_while_empty", e.id), 64'(viol), 64'd0);
        chk($sformatf("t%0d_done_latency", e.id), 64'(cyc - last_rd), 64'd2);
        chk($sformatf("t%0d_busy_in_done", e.id), {63'd0, busy}, 64'd0);
      end
    end
    done_q = done;
  end

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    push_cnt++;
  endtask

  task automatic flush();
    int n;
    n = fq.size();
    fq.delete();
    push_cnt = push_cnt - n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] pat);
    pattern = pat;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    // Later pattern changes must not affect the run in progress.
    pattern = ~pat;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=timeout required=done");
    end
    tick();
  endtask

  task automatic do_run(input logic [31:0] pat, input logic [31:0] n, input exp_t e);
    expected_words = n;
    exp_q.push_back(e);
    pulse_start(pat);
    wait_done();
    flush();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; pattern = 32'd0; start = 1'b0; stop = 1'b0; expected_words = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error_flag", {63'd0, error_flag}, 64'd0);
    chk("rst_word_count", word_count, 64'd0);
    chk("rst_error_count", {32'd0, error_count}, 64'd0);
    chk("rst_cap_index", {32'd0, first_err_index}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) push(i);
    do_run(32'd0, 32'd16, mk(1, 16, 0, 0, 0, 0, 0, 16));

    for (int i = 0; i < 16; i++)
      push(i == 5 ? 32'hDEAD_BEEF : i == 9 ? 32'h1234_5678 : i);
    do_run(32'd0, 32'd16, mk(2, 16, 2, 1, 5, 32'h5, 32'hDEAD_BEEF, 16));

    push(32'h1); push(32'h3); push(32'h6); push(32'hD);
    do_run(32'd2, 32'd4, mk(3, 4, 0, 0, 0, 0, 0, 4));

    push(32'h1); push(32'h2); push(32'h4); push(32'h8);
    do_run(32'd2, 32'd4, mk(4, 4, 3, 1, 1, 32'h3, 32'h2, 4));

    push(32'h1); push(32'h2); push(32'h4); push(32'h8);
    do_run(32'd1, 32'd4, mk(5, 4, 0, 0, 0, 0, 0, 4));

    push(32'hAAAA_AAAA); push(32'h5555_5555); push(32'hAAAA_AAAA);
    do_run(32'd3, 32'd3, mk(6, 3, 0, 0, 0, 0, 0, 3));

    push(32'h1579_A024); push(32'h1579_A025); push(32'h1579_A024);
    do_run(32'hABCD_0125, 32'd3, mk(7, 3, 1, 1, 1, 32'h1579_A024, 32'h1579_A025, 3));

    for (int i = 0; i < 8; i++) push(i);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          empty_force = ~empty_force;
          tick();
        end
        empty_force = 1'b0;
      end
      do_run(32'd0, 32'd8, mk(8, 8, 0, 0, 0, 0, 0, 8));
    join

    for (int i = 0; i < 20; i++) push(i);
    expected_words = 32'd0;
    exp_q.push_back(mk(9, 11, 0, 0, 0, 0, 0, 11));
    pulse_start(32'd0);
    n = 0;
    for (int i = 0; i < 100 && n < 11; i++) begin
      if (fifo_rd_en) n++;
      if (n == 11) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("t9_stop_reached", 64'(n), 64'd11);
    wait_done();
    flush();

    for (int i = 0; i < 16; i++) push(i);
    expected_words = 32'd16;
    pulse_start(32'd0);
    for (int i = 0; i < 100; i++) begin
      if (word_count == 64'd7) break;
      tick();
    end
    chk("t10_reached_wc7", word_count, 64'd7);
    reset = 1'b1;
    #1;
    chk("t10_rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    chk("t10_rst_busy", {63'd0, busy}, 64'd0);
    chk("t10_rst_done", {63'd0, done}, 64'd0);
    chk("t10_rst_word_count", word_count, 64'd0);
    chk("t10_rst_error_flag", {63'd0, error_flag}, 64'd0);
    tick();
    reset = 1'b0;
    flush();
    tick();

    for (int i = 0; i < 5; i++) push(i);
    do_run(32'd0, 32'd5, mk(11, 5, 0, 0, 0, 0, 0, 5));

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
